// File: rtl/timer_pkg.sv
// Shared types and constants for the timer controller slice.
package timer_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CNT_W_DEF = 16;
    localparam int PSC_W_DEF = 8;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_ctrl_if.sv
// Config/status bundle between the register interface and the timer controller.
interface timer_ctrl_if
    import timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PSC_W = PSC_W_DEF
) ();

    logic             start;
    logic             stop;
    logic             mode;
    logic [CNT_W-1:0] load_val;
    logic [PSC_W-1:0] psc_val;
    logic             ce_out;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             expired;

    modport master (
        output start, stop, mode, load_val, psc_val,
        input  ce_out, cnt, busy, expired
    );

    modport slave (
        input  start, stop, mode, load_val, psc_val,
        output ce_out, cnt, busy, expired
    );

endinterface

// File: rtl/timer_prescaler.sv
// Prescale down-counter: reloads on load, counts when enabled, wraps by explicit reload.
module timer_prescaler #(
    parameter int PSC_W = 8
) (
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [PSC_W-1:0] i_reload,
    output logic             o_tick
);

    logic [PSC_W-1:0] r_cnt;

    // Prescale counter: load has priority, then reload-on-zero or decrement while enabled.
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_cnt <= {PSC_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_reload;
        end else if (i_en) begin
            if (r_cnt == {PSC_W{1'b0}}) begin
                r_cnt <= i_reload;
            end else begin
                r_cnt <= r_cnt - PSC_W'(1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Tick marks the last cycle of each prescale period.
    assign o_tick = (r_cnt == {PSC_W{1'b0}});

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: sequences LOAD/RUN, owns the main down-counter and the ce strobe.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PSC_W = PSC_W_DEF
) (
    input  logic         clk,
    input  logic         clr_n,
    timer_ctrl_if.slave  bus
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_load_q;
    logic [PSC_W-1:0] r_psc_q;
    logic             r_mode_q;
    logic             r_expired;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_expired_nxt;
    logic             w_capture;
    logic             w_psc_load;
    logic             w_psc_en;
    logic             w_tick;
    logic             w_load_nz;

    assign w_load_nz = (bus.load_val != {CNT_W{1'b0}});

    timer_prescaler #(.PSC_W(PSC_W)) u_psc (
        .i_clk    (clk),
        .i_clr_n  (clr_n),
        .i_load   (w_psc_load),
        .i_en     (w_psc_en),
        .i_reload (r_psc_q),
        .o_tick   (w_tick)
    );

    // State, main counter, captured config and expiry pulse registers.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state   <= IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_load_q  <= {CNT_W{1'b0}};
            r_psc_q   <= {PSC_W{1'b0}};
            r_mode_q  <= MODE_ONESHOT;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_expired <= w_expired_nxt;
            if (w_capture) begin
                r_load_q <= bus.load_val;
                r_psc_q  <= bus.psc_val;
                r_mode_q <= bus.mode;
            end else begin
                r_load_q <= r_load_q;
                r_psc_q  <= r_psc_q;
                r_mode_q <= r_mode_q;
            end
        end
    end

    // Next-state and datapath control; stop outranks re-arm, which outranks tick/expiry.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_expired_nxt = 1'b0;
        w_capture     = 1'b0;
        w_psc_load    = 1'b0;
        w_psc_en      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && !bus.stop && w_load_nz) begin
                    w_capture   = 1'b1;
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            LOAD: begin
                if (bus.stop) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = r_load_q;
                    w_psc_load  = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    w_state_nxt = IDLE;
                end else if (bus.start && w_load_nz) begin
                    // Re-arm discards whatever tick was due this edge.
                    w_capture   = 1'b1;
                    w_state_nxt = LOAD;
                end else begin
                    w_psc_en = 1'b1;
                    if (w_tick && (r_cnt == CNT_W'(1))) begin
                        w_expired_nxt = 1'b1;
                        if (r_mode_q == MODE_PERIODIC) begin
                            // Reload in place so the period has no LOAD bubble.
                            w_cnt_nxt = r_load_q;
                        end else begin
                            w_cnt_nxt   = {CNT_W{1'b0}};
                            w_state_nxt = DONE;
                        end
                    end else if (w_tick) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.ce_out  = (r_state == RUN) && w_tick;
    assign bus.busy    = (r_state == LOAD) || (r_state == RUN);
    assign bus.cnt     = r_cnt;
    assign bus.expired = r_expired;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios plus randomized traffic
// compared against an arithmetic model of elapsed run time.
module tb_timer_ctrl;

    localparam int CW = timer_pkg::CNT_W_DEF;
    localparam int PW = timer_pkg::PSC_W_DEF;

    localparam int MP_IDLE = 0;
    localparam int MP_LOAD = 1;
    localparam int MP_RUN  = 2;
    localparam int MP_DONE = 3;

    logic clk   = 1'b0;
    logic clr_n = 1'b0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    timer_ctrl_if #(.CNT_W(CW), .PSC_W(PW)) bus ();

    timer_ctrl #(.CNT_W(CW), .PSC_W(PW)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase, captured config, cycles elapsed in RUN, held count.
    int m_phase = MP_IDLE;
    int m_n     = 0;
    int m_p     = 0;
    int m_e     = 0;
    int m_hold  = 0;
    bit m_mode  = 1'b0;
    bit m_exp   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Count during RUN follows from the number of whole prescale periods elapsed.
    function automatic int m_cnt();
        int t;
        if (m_phase == MP_RUN) begin
            t = m_e / (m_p + 1);
            if (m_mode) return m_n - (t % m_n);
            else        return m_n - t;
        end
        return m_hold;
    endfunction

    function automatic bit m_ce();
        return (m_phase == MP_RUN) && ((m_e % (m_p + 1)) == m_p);
    endfunction

    task automatic model_step(input bit st, input bit sp, input bit md,
                              input int lv, input int pv, input bit rn);
        int c;
        bit nexp;
        if (!rn) begin
            m_phase = MP_IDLE; m_hold = 0; m_exp = 1'b0;
            m_n = 0; m_p = 0; m_mode = 1'b0; m_e = 0;
            return;
        end
        c    = m_cnt();
        nexp = 1'b0;
        case (m_phase)
            MP_IDLE: if (st && !sp && lv != 0) begin
                m_n = lv; m_p = pv; m_mode = md; m_phase = MP_LOAD;
            end
            MP_LOAD: if (sp) m_phase = MP_IDLE;
                     else begin m_phase = MP_RUN; m_e = 0; end
            MP_RUN: begin
                if (sp) begin
                    m_hold = c; m_phase = MP_IDLE;
                end else if (st && lv != 0) begin
                    m_hold = c; m_n = lv; m_p = pv; m_mode = md; m_phase = MP_LOAD;
                end else if (m_ce() && c == 1) begin
                    nexp = 1'b1;
                    if (m_mode) m_e++;
                    else begin m_hold = 0; m_phase = MP_DONE; end
                end else begin
                    m_e++;
                end
            end
            default: m_phase = MP_IDLE;
        endcase
        m_exp = nexp;
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 ns later.
    task automatic cyc(input bit st, input bit sp, input bit md,
                       input int lv, input int pv, input bit rn);
        logic [31:0] lv_v;
        logic [31:0] pv_v;
        lv_v = lv;
        pv_v = pv;
        bus.start    = st;
        bus.stop     = sp;
        bus.mode     = md;
        bus.load_val = lv_v[CW-1:0];
        bus.psc_val  = pv_v[PW-1:0];
        clr_n        = rn;
        @(posedge clk);
        model_step(st, sp, md, lv, pv, rn);
        #1;
        chk("cnt",     32'(bus.cnt),     32'(m_cnt()));
        chk("busy",    32'(bus.busy),    32'(m_phase == MP_LOAD || m_phase == MP_RUN));
        chk("ce_out",  32'(bus.ce_out),  32'(m_ce()));
        chk("expired", 32'(bus.expired), 32'(m_exp));
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    initial begin
        int n_exp;
        bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
        bus.load_val = '0; bus.psc_val = '0;

        // Reset state.
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("rst_cnt", 32'(bus.cnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        idle_cyc();

        // One-shot N=3 P=1: ce after E2/E4/E6, expiry after E7, idle after E8.
        cyc(1'b1, 1'b0, 1'b0, 3, 1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            idle_cyc();
            chk("os_ce",  32'(bus.ce_out),  32'(i == 2 || i == 4 || i == 6));
            chk("os_exp", 32'(bus.expired), 32'(i == 7));
            chk("os_busy", 32'(bus.busy),   32'(i <= 6));
        end
        chk("os_cnt_end", 32'(bus.cnt), 32'd0);

        // Periodic N=2 P=0: four expiries in eight RUN cycles.
        cyc(1'b1, 1'b0, 1'b1, 2, 0, 1'b1);
        idle_cyc();
        n_exp = 0;
        for (int i = 0; i < 8; i++) begin
            idle_cyc();
            chk("per_ce", 32'(bus.ce_out), 32'd1);
            if (bus.expired) n_exp++;
        end
        chk("per_exp_count", 32'(n_exp), 32'd4);
        cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);

        // Stop on the final tick of N=5 P=2.
        cyc(1'b1, 1'b0, 1'b0, 5, 2, 1'b1);
        repeat (15) idle_cyc();
        chk("sp_pre_ce", 32'(bus.ce_out), 32'd1);
        chk("sp_pre_cnt", 32'(bus.cnt), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
        chk("sp_cnt", 32'(bus.cnt), 32'd1);
        chk("sp_busy", 32'(bus.busy), 32'd0);
        chk("sp_exp", 32'(bus.expired), 32'd0);
        idle_cyc();
        chk("sp_exp2", 32'(bus.expired), 32'd0);

        // Re-arm mid-run with N=4, then let it expire.
        cyc(1'b1, 1'b0, 1'b0, 6, 1, 1'b1);
        repeat (5) idle_cyc();
        cyc(1'b1, 1'b0, 1'b0, 4, 0, 1'b1);
        chk("ra_load_busy", 32'(bus.busy), 32'd1);
        idle_cyc();
        chk("ra_cnt", 32'(bus.cnt), 32'd4);
        repeat (6) idle_cyc();

        // Start and stop together from IDLE.
        cyc(1'b1, 1'b1, 1'b0, 3, 0, 1'b1);
        chk("ss_busy", 32'(bus.busy), 32'd0);

        // Zero load is ignored.
        cyc(1'b1, 1'b0, 1'b0, 0, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            idle_cyc();
            chk("zl_busy", 32'(bus.busy), 32'd0);
            chk("zl_ce", 32'(bus.ce_out), 32'd0);
        end

        // Reset mid-run.
        cyc(1'b1, 1'b0, 1'b1, 4, 1, 1'b1);
        repeat (4) idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        chk("mr_cnt", 32'(bus.cnt), 32'd0);
        chk("mr_exp", 32'(bus.expired), 32'd0);
        chk("mr_busy", 32'(bus.busy), 32'd0);
        chk("mr_ce", 32'(bus.ce_out), 32'd0);
        idle_cyc();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit st;
            bit sp;
            bit md;
            bit rn;
            int lv;
            int pv;
            st = ($urandom_range(7) == 0);
            sp = ($urandom_range(24) == 0);
            md = 1'($urandom_range(1));
            lv = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(6, 1));
            pv = int'($urandom_range(3));
            rn = ($urandom_range(299) != 0);
            cyc(st, sp, md, lv, pv, rn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Controller that sequences the timer's DFF-based count chain.
- Captures a reload value and a prescale value, then generates the clock-enable (ce) strobe for the flip-flop bank.
- Runs a down-count in one-shot or periodic mode and flags expiry with a single-cycle pulse.
- Sits between the register/config interface and the ms_dff count datapath. It is the only source of that datapath's ce.

Parameters:
- CNT_W, 16, width of the main down-counter and of load_val.
- PSC_W, 8, width of the prescaler counter and of psc_val.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr_n  input  1  synchronous active-low reset.
- start  input  1  arm/re-arm request, sampled each edge.
- stop  input  1  abort request; has priority over start and over expiry.
- mode  input  1  0 = one-shot, 1 = periodic; captured at start.
- load_val  input  CNT_W  reload count N; captured at start.
- psc_val  input  PSC_W  prescale P; tick period is P+1 cycles; captured at start.
- ce_out  output  1  count-enable strobe to the DFF bank; one cycle per tick.
- cnt  output  CNT_W  current count value.
- busy  output  1  high in LOAD and RUN.
- expired  output  1  registered one-cycle pulse on terminal count.

Behaviour:
- Reset (clr_n=0 at an edge): state IDLE; cnt=0, psc counter=0, captured regs=0, expired=0. busy=0 and ce_out=0 in the following cycle.
- States are IDLE, LOAD, RUN, DONE. busy = (state==LOAD || state==RUN). ce_out = (state==RUN && psc_cnt==0) is a combinational decode of registered state.
- IDLE:
  - start=1, stop=0, load_val!=0: capture load_val/psc_val/mode, go to LOAD.
  - start with load_val==0 is ignored; stay in IDLE.
  - cnt holds its last value.
- LOAD (exactly 1 cycle): cnt<=load_q, psc_cnt<=psc_q, go to RUN.
- RUN, each edge with no stop or start:
  - If psc_cnt!=0: psc_cnt decrements.
  - If psc_cnt==0 (tick): psc_cnt<=psc_q and cnt decrements.
  - Tick with cnt==1, one-shot: cnt<=0, expired<=1, go to DONE.
  - Tick with cnt==1, periodic: cnt<=load_q, expired<=1, stay in RUN. There is no LOAD bubble, so the period is exactly N*(P+1) cycles.
- DONE: lasts 1 cycle, then IDLE. start is ignored in DONE.
- stop=1 in LOAD/RUN: go to IDLE next edge. cnt freezes at its current value, no tick and no expired that edge, even if the expiry condition holds.
- start=1 in RUN (stop=0): re-arm. Capture fresh inputs and go to LOAD; the pending tick/expiry that edge is discarded.
- start and stop in the same cycle: stop wins.
- Latency: if start is sampled at edge E0, expired is high during the cycle after edge E0+1+N*(P+1).
- P=0: a tick occurs every RUN cycle.
- N=1: expires on the first tick.
- Wrap-around: counters never wrap; the reload is explicit.
- Reset mid-RUN: immediate return to reset values at the next edge; no expired pulse.

Decomposition:
- Package timer_pkg holds:
  - state enum {IDLE, LOAD, RUN, DONE} (2-bit);
  - default width constants CNT_W_DEF=16 and PSC_W_DEF=8;
  - mode encoding constants MODE_ONESHOT=0 and MODE_PERIODIC=1.
- One sub-module, timer_prescaler, contains the PSC_W down-counter with reload, enable, clear, and tick output. It is instantiated once, and the FSM and main counter stay in timer_ctrl.

Test Plan:
- One-shot: N=3, P=1, mode=0, single-cycle start at E0 -> ce_out high in the cycles after E2, E4, E6. cnt reads 3,2,1,0. expired is high for exactly the cycle after E7. busy drops after E7 and the block returns to IDLE after E8.
- Periodic: N=2, P=0, mode=1 -> ce_out high every RUN cycle. expired pulses every 2 cycles, 4 times in 8 cycles. cnt sequence is 2,1,2,1,…
- Stop priority: N=5, P=2 run, then stop asserted on the exact cycle of the final tick (cnt==1, psc_cnt==0) -> no expired, cnt frozen at 1, state IDLE, busy=0.
- Re-arm and start/stop collision:
  - start pulsed again mid-RUN with N=4 -> one LOAD cycle, cnt reloads to 4, no expired from the first run.
  - start and stop together -> state unchanged at IDLE.
- Zero load and reset:
  - start with load_val=0 -> busy stays 0 and ce_out never pulses.
  - clr_n=0 mid-RUN -> at the next edge cnt=0 and expired=0; busy=0 and ce_out=0 in the following cycle.
